// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameters for the IF/DM unified-memory arbiter.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_BUSY = 2'd1;
    localparam arb_state_t ST_RESP = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } grant_t;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch (read-only)
// and data memory (read/write); one access at a time through IDLE -> BUSY -> RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        dbg_state,
    output owner_t            dbg_owner,
    output logic [CNT_W-1:0]  dbg_starve_cnt,
    output logic              dbg_kill
);

    // Handshake: a requester raises *_req with its address/data stable and keeps
    // them until its *_valid pulse; *_valid is a single-cycle completion strobe
    // and *_stall stays high for every cycle the request is held before it.

    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              kill_q, kill_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;

    logic   if_elig;
    grant_t gnt;

    // DM has priority unless IF has watched STARVE_LIMIT DM grants go by.
    function automatic grant_t pick_grant(input logic if_ok, input logic dm_ok,
                                          input logic if_starved);
        grant_t g;
        g.valid = if_ok | dm_ok;
        g.owner = (dm_ok && !(if_ok && if_starved)) ? OWN_DM : OWN_IF;
        return g;
    endfunction

    assign if_elig = if_req & ~flush;
    assign gnt     = pick_grant(if_elig, dm_req, starve_q == STARVE_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        kill_d     = kill_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (gnt.valid) begin
                    state_d  = ST_BUSY;
                    owner_d  = gnt.owner;
                    cnt_d    = LAT_INIT;
                    mem_en_d = 1'b1;
                    if (gnt.owner == OWN_DM) begin
                        we_d     = dm_we;
                        addr_d   = dm_addr;
                        wdata_d  = dm_wdata;
                        mem_we_d = dm_we;
                        if (if_elig) begin
                            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                        end else if (!if_req) begin
                            starve_d = '0;
                        end
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        starve_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (flush && owner_q == OWN_IF) begin
                    kill_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if (!kill_d) begin
                            if_rdata_d = mem_rdata;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_valid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            kill_q     <= kill_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // A killed IF access still occupies RESP, but must not release the fetch stall.
    assign if_stall = if_req & ~(state_q == ST_RESP && owner_q == OWN_IF && !kill_q);
    assign dm_stall = dm_req & ~(state_q == ST_RESP && owner_q == OWN_DM);

    assign if_rdata       = if_rdata_q;
    assign dm_rdata       = dm_rdata_q;
    assign if_valid       = if_valid_q;
    assign dm_valid       = dm_valid_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign dbg_state      = state_q;
    assign dbg_owner      = owner_q;
    assign dbg_starve_cnt = starve_q;
    assign dbg_kill       = kill_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=2, STARVE_LIMIT=4 and a small
// behavioural memory that returns read data two cycles after mem_en.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, flush;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;
    arb_state_t  dbg_state;
    owner_t      dbg_owner;
    logic [3:0]  dbg_starve_cnt;
    logic        dbg_kill;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .if_stall(if_stall), .flush(flush),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_starve_cnt(dbg_starve_cnt),
        .dbg_kill(dbg_kill)
    );

    always #5 clk = ~clk;

    // Behavioural memory: fixed base contents plus a write overlay.
    logic        mem_clear;
    logic [31:0] wr_data [0:255];
    logic [255:0] wr_valid;
    logic [31:0] rd_pipe0, rd_pipe1;
    logic [1:0]  rd_v;

    function automatic logic [31:0] base_word(input logic [7:0] idx);
        case (idx)
            8'd4:    return 32'hDEAD_BEEF;
            8'd5:    return 32'h1234_5678;
            8'd64:   return 32'hCAFE_F00D;
            default: return {24'hA5A5A5, idx};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            wr_valid <= '0;
            rd_v     <= '0;
        end else begin
            rd_v <= {rd_v[0], mem_en & ~mem_we};
            if (mem_en && mem_we) begin
                wr_data[mem_addr[9:2]]  <= mem_wdata;
                wr_valid[mem_addr[9:2]] <= 1'b1;
            end
        end
        rd_pipe0 <= wr_valid[mem_addr[9:2]] ? wr_data[mem_addr[9:2]] : base_word(mem_addr[9:2]);
        rd_pipe1 <= rd_pipe0;
    end

    assign mem_rdata = rd_v[1] ? rd_pipe1 : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_clear = 1'b1; idle_inputs();
        tick(); tick();
        mem_clear = 1'b0;
        n_checks++;
        if ({dbg_state, dbg_owner, dbg_starve_cnt, dbg_kill} !== {ST_IDLE, OWN_IF, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fsm: got state=%0d owner=%0d starve=%0d kill=%0b, expected 0/0/0/0",
                     dbg_state, dbg_owner, dbg_starve_cnt, dbg_kill);
        end
        n_checks++;
        if ({if_rdata, dm_rdata, if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got if_rdata=%h dm_rdata=%h valids=%b%b en/we=%b%b addr=%h wdata=%h, expected all 0",
                     if_rdata, dm_rdata, if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({dbg_state, mem_en} !== {ST_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_no_req: got state=%0d mem_en=%b, expected 0/0", dbg_state, mem_en);
        end
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        n_checks++;
        if (if_stall !== 1'b1) begin n_fail++; $display("FAIL if_read_stall_c0: got %b expected 1", if_stall); end
        tick();
        n_checks++;
        if ({mem_en, mem_we, mem_addr, if_stall} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
            n_fail++;
            $display("FAIL if_read_c1: got en=%b we=%b addr=%h stall=%b, expected 1 0 00000010 1",
                     mem_en, mem_we, mem_addr, if_stall);
        end
        tick();
        n_checks++;
        if ({mem_en, if_stall, dbg_state} !== {1'b0, 1'b1, ST_BUSY}) begin
            n_fail++;
            $display("FAIL if_read_c2: got en=%b stall=%b state=%0d, expected 0 1 1", mem_en, if_stall, dbg_state);
        end
        tick();
        n_checks++;
        if ({if_valid, if_stall} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL if_read_c3: got valid=%b stall=%b, expected 0 1", if_valid, if_stall);
        end
        tick();
        n_checks++;
        if ({if_valid, if_rdata, if_stall} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL if_read_c4: got valid=%b rdata=%h stall=%b, expected 1 deadbeef 0",
                     if_valid, if_rdata, if_stall);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if ({if_valid, dbg_state} !== {1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL if_read_c5: got valid=%b state=%0d, expected 0 0", if_valid, dbg_state);
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        n_checks++;
        if ({mem_en, mem_addr, dbg_owner, dbg_starve_cnt} !== {1'b1, 32'h100, OWN_DM, 4'd1}) begin
            n_fail++;
            $display("FAIL simul_dm_grant: got en=%b addr=%h owner=%0d starve=%0d, expected 1 00000100 1 1",
                     mem_en, mem_addr, dbg_owner, dbg_starve_cnt);
        end
        repeat (3) tick();
        n_checks++;
        if ({dm_valid, dm_rdata, dm_stall, if_stall, if_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_dm_resp: got dvalid=%b drdata=%h dstall=%b istall=%b ivalid=%b, expected 1 cafef00d 0 1 0",
                     dm_valid, dm_rdata, dm_stall, if_stall, if_valid);
        end
        dm_req = 1'b0;
        tick();
        n_checks++;
        if ({dbg_state, mem_en, dm_valid} !== {ST_IDLE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_c5: got state=%0d en=%b dvalid=%b, expected 0 0 0", dbg_state, mem_en, dm_valid);
        end
        tick();
        n_checks++;
        if ({mem_en, mem_addr, dbg_owner, dbg_starve_cnt} !== {1'b1, 32'h10, OWN_IF, 4'd0}) begin
            n_fail++;
            $display("FAIL simul_if_grant: got en=%b addr=%h owner=%0d starve=%0d, expected 1 00000010 0 0",
                     mem_en, mem_addr, dbg_owner, dbg_starve_cnt);
        end
        repeat (3) tick();
        n_checks++;
        if ({if_valid, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL simul_if_resp: got valid=%b rdata=%h, expected 1 deadbeef", if_valid, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_dm_write();
        logic extra;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        tick();
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h55}) begin
            n_fail++;
            $display("FAIL write_strobe: got en=%b we=%b addr=%h wdata=%h, expected 1 1 00000020 00000055",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        extra = 1'b0;
        repeat (2) begin
            tick();
            extra = extra | mem_en | mem_we;
        end
        n_checks++;
        if (extra !== 1'b0) begin n_fail++; $display("FAIL write_single_strobe: got extra strobe=%b expected 0", extra); end
        tick();
        n_checks++;
        if ({dm_valid, dm_rdata, mem_en, dm_stall} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL write_ack: got valid=%b rdata=%h en=%b stall=%b, expected 1 cafef00d 0 0",
                     dm_valid, dm_rdata, mem_en, dm_stall);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        tick();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h20}) begin
            n_fail++;
            $display("FAIL b2b_first_strobe: got en=%b addr=%h, expected 1 00000020", mem_en, mem_addr);
        end
        repeat (3) tick();
        n_checks++;
        if ({dm_valid, dm_rdata} !== {1'b1, 32'h55}) begin
            n_fail++;
            $display("FAIL b2b_readback: got valid=%b rdata=%h, expected 1 00000055", dm_valid, dm_rdata);
        end
        dm_addr = 32'h100;
        tick();
        n_checks++;
        if ({mem_en, dbg_state} !== {1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL b2b_gap: got en=%b state=%0d, expected 0 0", mem_en, dbg_state);
        end
        tick();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL b2b_second_strobe: got en=%b addr=%h, expected 1 00000100", mem_en, mem_addr);
        end
        repeat (3) tick();
        n_checks++;
        if ({dm_valid, dm_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL b2b_second_resp: got valid=%b rdata=%h, expected 1 cafef00d", dm_valid, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_q[$];
        logic [3:0]  exp_s [5];
        int          g;
        logic        saw_if_valid;
        exp_q = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h10};
        exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        g = 0;
        saw_if_valid = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        for (int c = 0; c < 40 && !saw_if_valid; c++) begin
            tick();
            if (mem_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL starve_extra_grant: got addr=%h, expected no further grant", mem_addr);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (mem_addr !== e || dbg_starve_cnt !== exp_s[g]) begin
                        n_fail++;
                        $display("FAIL starve_grant%0d: got addr=%h starve=%0d, expected %h %0d",
                                 g, mem_addr, dbg_starve_cnt, e, exp_s[g]);
                    end
                    g++;
                end
            end
            if (if_valid) saw_if_valid = 1'b1;
        end
        n_checks++;
        if (saw_if_valid !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL starve_if_served: got if_valid_seen=%b grants_left=%0d, expected 1 0",
                     saw_if_valid, exp_q.size());
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h10; flush = 1'b1;
        tick();
        n_checks++;
        if ({mem_en, dbg_state} !== {1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL flush_blocks_grant: got en=%b state=%0d, expected 0 0", mem_en, dbg_state);
        end
        flush = 1'b0;
        tick();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL flush_access_start: got en=%b addr=%h, expected 1 00000010", mem_en, mem_addr);
        end
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({dbg_kill, if_valid} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_kill_set: got kill=%b valid=%b, expected 1 0", dbg_kill, if_valid);
        end
        tick();
        n_checks++;
        if ({if_valid, dbg_state, if_rdata} !== {1'b0, ST_RESP, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL flush_no_valid: got valid=%b state=%0d rdata=%h, expected 0 2 deadbeef",
                     if_valid, dbg_state, if_rdata);
        end
        tick();
        n_checks++;
        if ({dbg_state, dbg_kill} !== {ST_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_back_idle: got state=%0d kill=%b, expected 0 0", dbg_state, dbg_kill);
        end
        if_req = 1'b1; if_addr = 32'h14;
        tick();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h14}) begin
            n_fail++;
            $display("FAIL flush_next_strobe: got en=%b addr=%h, expected 1 00000014", mem_en, mem_addr);
        end
        repeat (3) tick();
        n_checks++;
        if ({if_valid, if_rdata, if_stall} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_next_read: got valid=%b rdata=%h stall=%b, expected 1 12345678 0",
                     if_valid, if_rdata, if_stall);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        logic any_valid;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        tick();
        reset = 1'b0; if_req = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if ({dbg_state, mem_en, if_valid, dm_valid, if_rdata, dm_rdata} !== {ST_IDLE, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got state=%0d en=%b valids=%b%b if_rdata=%h dm_rdata=%h, expected 0 0 00 0 0",
                     dbg_state, mem_en, if_valid, dm_valid, if_rdata, dm_rdata);
        end
        any_valid = 1'b0;
        repeat (4) begin
            tick();
            any_valid = any_valid | if_valid | dm_valid | mem_en;
        end
        n_checks++;
        if (any_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_late_pulse: got activity=%b expected 0", any_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_if_read();
        test_simultaneous();
        test_dm_write();
        test_back_to_back();
        test_starvation();
        test_flush();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
